// File: rtl/cnn_pkg.sv
// Shared CNN classifier types and constants: Q8.8 score type, class count and
// the classifier FSM encoding.
package cnn_pkg;

    localparam int          N_CLASS   = 10;
    localparam int          DW        = 16;
    localparam int          FRAC_BITS = 8;
    localparam logic [15:0] SCORE_MIN = 16'sh8000;

    typedef logic signed [DW-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/softmax_argmax_if.sv
// Request/result bundle between the FCL2 frame latch, the argmax classifier
// and the downstream result/display logic.
interface softmax_argmax_if #(
    parameter int CNT_W = 16
) ();

    logic               start;
    logic [15:0]        in_sm_1;
    logic [15:0]        in_sm_2;
    logic [15:0]        in_sm_3;
    logic [15:0]        in_sm_4;
    logic [15:0]        in_sm_5;
    logic [15:0]        in_sm_6;
    logic [15:0]        in_sm_7;
    logic [15:0]        in_sm_8;
    logic [15:0]        in_sm_9;
    logic [15:0]        in_sm_10;
    logic               busy;
    logic               done;
    logic [3:0]         class_idx;
    logic [15:0]        max_val;
    logic [15:0]        second_val;
    logic [16:0]        margin;
    logic [CNT_W-1:0]   result_cnt;

    modport master (
        output start, in_sm_1, in_sm_2, in_sm_3, in_sm_4, in_sm_5,
               in_sm_6, in_sm_7, in_sm_8, in_sm_9, in_sm_10,
        input  busy, done, class_idx, max_val, second_val, margin, result_cnt
    );

    modport slave (
        input  start, in_sm_1, in_sm_2, in_sm_3, in_sm_4, in_sm_5,
               in_sm_6, in_sm_7, in_sm_8, in_sm_9, in_sm_10,
        output busy, done, class_idx, max_val, second_val, margin, result_cnt
    );

endinterface

// File: rtl/top2_tracker.sv
// Combinational best/runner-up update for one incoming signed score; a strict
// compare keeps the earliest index on ties and demotes the tie into second.
module top2_tracker
    import cnn_pkg::*;
(
    input  score_t      v_i,
    input  logic [3:0]  idx_i,
    input  score_t      best_val_i,
    input  logic [3:0]  best_idx_i,
    input  score_t      sec_val_i,
    output score_t      best_val_o,
    output logic [3:0]  best_idx_o,
    output score_t      sec_val_o
);

    // Rank the new value against the current top two.
    always_comb begin
        best_val_o = best_val_i;
        best_idx_o = best_idx_i;
        sec_val_o  = sec_val_i;
        if (v_i > best_val_i) begin
            sec_val_o  = best_val_i;
            best_val_o = v_i;
            best_idx_o = idx_i;
        end else if (v_i > sec_val_i) begin
            sec_val_o  = v_i;
        end else begin
            sec_val_o  = sec_val_i;
        end
    end

endmodule

// File: rtl/softmax_argmax.sv
// Argmax classifier: snapshots ten FCL2 scores on start, scans them one per
// cycle, then publishes winner, top-two scores, margin and a run counter.
module softmax_argmax
    import cnn_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    softmax_argmax_if.slave   bus
);

    state_t             state_q, state_d;
    score_t             snap_q [N_CLASS];
    score_t             snap_d [N_CLASS];
    logic [3:0]         idx_q, idx_d;
    score_t             best_val_q, best_val_d;
    logic [3:0]         best_idx_q, best_idx_d;
    score_t             sec_val_q, sec_val_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         class_idx_q, class_idx_d;
    score_t             max_val_q, max_val_d;
    score_t             second_val_q, second_val_d;
    logic [16:0]        margin_q, margin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    score_t             trk_best_val_s;
    logic [3:0]         trk_best_idx_s;
    score_t             trk_sec_val_s;

    top2_tracker u_tracker (
        .v_i        (snap_q[idx_q]),
        .idx_i      (idx_q),
        .best_val_i (best_val_q),
        .best_idx_i (best_idx_q),
        .sec_val_i  (sec_val_q),
        .best_val_o (trk_best_val_s),
        .best_idx_o (trk_best_idx_s),
        .sec_val_o  (trk_sec_val_s)
    );

    // State, snapshot, working and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < N_CLASS; i++) snap_q[i] <= SCORE_MIN;
            idx_q        <= 4'd0;
            best_val_q   <= SCORE_MIN;
            best_idx_q   <= 4'd0;
            sec_val_q    <= SCORE_MIN;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            class_idx_q  <= 4'd0;
            max_val_q    <= SCORE_MIN;
            second_val_q <= SCORE_MIN;
            margin_q     <= 17'd0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            sec_val_q    <= sec_val_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            class_idx_q  <= class_idx_d;
            max_val_q    <= max_val_d;
            second_val_q <= second_val_d;
            margin_q     <= margin_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state: accept start only in IDLE, scan ten entries, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? SCAN : IDLE;
            SCAN:    state_d = (idx_q == 4'(N_CLASS - 1)) ? DONE : SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs; everything holds unless the current state updates it.
    always_comb begin
        snap_d       = snap_q;
        idx_d        = idx_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        sec_val_d    = sec_val_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        class_idx_d  = class_idx_q;
        max_val_d    = max_val_q;
        second_val_d = second_val_q;
        margin_d     = margin_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d[0]  = bus.in_sm_1;
                    snap_d[1]  = bus.in_sm_2;
                    snap_d[2]  = bus.in_sm_3;
                    snap_d[3]  = bus.in_sm_4;
                    snap_d[4]  = bus.in_sm_5;
                    snap_d[5]  = bus.in_sm_6;
                    snap_d[6]  = bus.in_sm_7;
                    snap_d[7]  = bus.in_sm_8;
                    snap_d[8]  = bus.in_sm_9;
                    snap_d[9]  = bus.in_sm_10;
                    idx_d      = 4'd0;
                    best_val_d = SCORE_MIN;
                    best_idx_d = 4'd0;
                    sec_val_d  = SCORE_MIN;
                    busy_d     = 1'b1;
                end else begin
                    busy_d     = 1'b0;
                end
            end
            SCAN: begin
                best_val_d = trk_best_val_s;
                best_idx_d = trk_best_idx_s;
                sec_val_d  = trk_sec_val_s;
                idx_d      = idx_q + 4'd1;
            end
            DONE: begin
                class_idx_d  = best_idx_q;
                max_val_d    = best_val_q;
                second_val_d = sec_val_q;
                margin_d     = {best_val_q[DW-1], best_val_q} - {sec_val_q[DW-1], sec_val_q};
                done_d       = 1'b1;
                busy_d       = 1'b0;
                cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.class_idx  = class_idx_q;
    assign bus.max_val    = max_val_q;
    assign bus.second_val = second_val_q;
    assign bus.margin     = margin_q;
    assign bus.result_cnt = cnt_q;

endmodule
